// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM state type for the SPI-attached burst RAM.
package spi_ram_pkg;
   localparam logic [1:0] OP_SET_WADDR = 2'b00;
   localparam logic [1:0] OP_WRITE     = 2'b01;
   localparam logic [1:0] OP_SET_RADDR = 2'b10;
   localparam logic [1:0] OP_READ      = 2'b11;

   typedef enum logic {
      IDLE    = 1'b0,
      TX_HOLD = 1'b1
   } state_t;
endpackage

// File: rtl/spi_ram_burst_mem.sv
// Synchronous MEM_DEPTH x DATA_WIDTH array, one write port and one registered read port.
module spi_ram_burst_mem #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);
   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read register only moves on an accepted read, so it holds while tx is pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/spi_ram_burst.sv
// Command-decoded RAM behind an SPI slave: address/data commands, optional burst
// auto-increment, held tx_valid/tx_ack handshake and sticky error flags.
module spi_ram_burst
   import spi_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter bit AUTO_INC   = 1'b1,
   localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PW+1:0]         din,
   input  logic                  rx_valid,
   input  logic                  tx_ack,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  tx_valid,
   output logic                  addr_err,
   output logic                  seq_err,
   output logic                  ovf_err,
   output state_t                dbg_state
);
   localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

   // Handshake: dout is valid while tx_valid=1; a transfer completes in any
   // cycle where tx_valid=1 and tx_ack=1. tx_ack with tx_valid=0 is ignored.

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic                  r_wr_set, r_rd_set;
   logic                  r_addr_err, r_seq_err, r_ovf_err;

   logic [1:0]            w_op;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_addr_ok;
   logic                  w_set_wa, w_set_ra, w_wr_cmd, w_rd_cmd;
   logic                  w_wr_en, w_rd_req, w_rd_accept;

   function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] p);
      return (p == LP_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_op      = din[PW+1:PW];
   assign w_addr    = din[ADDR_WIDTH-1:0];
   assign w_data    = din[DATA_WIDTH-1:0];
   assign w_addr_ok = ({1'b0, w_addr} < LP_DEPTH);

   assign w_set_wa  = rx_valid && (w_op == OP_SET_WADDR);
   assign w_set_ra  = rx_valid && (w_op == OP_SET_RADDR);
   assign w_wr_cmd  = rx_valid && (w_op == OP_WRITE);
   assign w_rd_cmd  = rx_valid && (w_op == OP_READ);
   assign w_wr_en   = w_wr_cmd && r_wr_set;
   assign w_rd_req  = w_rd_cmd && r_rd_set;

   always_comb begin
      w_state_next = r_state;
      w_rd_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rd_req) begin
               w_rd_accept  = 1'b1;
               w_state_next = TX_HOLD;
            end
         end
         TX_HOLD: begin
            // A read is only taken in the same cycle the pending word is consumed.
            if (tx_ack) begin
               w_rd_accept  = w_rd_req;
               w_state_next = w_rd_req ? TX_HOLD : IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wr_set   <= 1'b0;
         r_rd_set   <= 1'b0;
         r_addr_err <= 1'b0;
         r_seq_err  <= 1'b0;
         r_ovf_err  <= 1'b0;
      end else begin
         if (w_set_wa) begin
            if (w_addr_ok) begin
               r_wr_ptr <= w_addr;
               r_wr_set <= 1'b1;
            end else begin
               r_addr_err <= 1'b1;
            end
         end
         if (w_set_ra) begin
            if (w_addr_ok) begin
               r_rd_ptr <= w_addr;
               r_rd_set <= 1'b1;
            end else begin
               r_addr_err <= 1'b1;
            end
         end
         if (w_wr_en && AUTO_INC) begin
            r_wr_ptr <= f_next(r_wr_ptr);
         end
         if (w_rd_accept && AUTO_INC) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         if ((w_wr_cmd && !r_wr_set) || (w_rd_cmd && !r_rd_set)) begin
            r_seq_err <= 1'b1;
         end
         if (w_rd_req && !w_rd_accept) begin
            r_ovf_err <= 1'b1;
         end
      end
   end

   spi_ram_burst_mem #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .i_wr_en  (w_wr_en),
      .i_wr_addr(r_wr_ptr),
      .i_wr_data(w_data),
      .i_rd_en  (w_rd_accept),
      .i_rd_addr(r_rd_ptr),
      .o_rd_data(dout)
   );

   assign tx_valid  = (r_state == TX_HOLD);
   assign addr_err  = r_addr_err;
   assign seq_err   = r_seq_err;
   assign ovf_err   = r_ovf_err;
   assign dbg_state = r_state;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: instance 0 is 256-deep with auto-increment, instance 1 is
// 200-deep with fixed pointers.
module tb_spi_ram_burst;
   import spi_ram_pkg::*;

   logic       clk;
   logic       rst      [2];
   logic [9:0] din      [2];
   logic       rx_valid [2];
   logic       tx_ack   [2];
   logic [7:0] dout     [2];
   logic       tx_valid [2];
   logic       addr_err [2];
   logic       seq_err  [2];
   logic       ovf_err  [2];
   state_t     dbg_state[2];

   int n_tests = 0;
   int n_fail  = 0;

   spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) dut0 (
      .clk(clk), .rst(rst[0]), .din(din[0]), .rx_valid(rx_valid[0]), .tx_ack(tx_ack[0]),
      .dout(dout[0]), .tx_valid(tx_valid[0]), .addr_err(addr_err[0]), .seq_err(seq_err[0]),
      .ovf_err(ovf_err[0]), .dbg_state(dbg_state[0])
   );

   spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1'b0)) dut1 (
      .clk(clk), .rst(rst[1]), .din(din[1]), .rx_valid(rx_valid[1]), .tx_ack(tx_ack[1]),
      .dout(dout[1]), .tx_valid(tx_valid[1]), .addr_err(addr_err[1]), .seq_err(seq_err[1]),
      .ovf_err(ovf_err[1]), .dbg_state(dbg_state[1])
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Driver tasks: called at a negedge, return at the next negedge after the command edge.
   task automatic cmd(input int d, input logic [1:0] op, input logic [7:0] pl, input logic ack);
      din[d]      = {op, pl};
      rx_valid[d] = 1'b1;
      tx_ack[d]   = ack;
      @(negedge clk);
      rx_valid[d] = 1'b0;
      tx_ack[d]   = 1'b0;
   endtask

   task automatic ack_only(input int d);
      tx_ack[d] = 1'b1;
      @(negedge clk);
      tx_ack[d] = 1'b0;
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst[d] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; din[i] = '0; rx_valid[i] = 1'b0; tx_ack[i] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Reset state
      chk("rst_tx_valid", tx_valid[0], 0);
      chk("rst_dout", dout[0], 0);
      chk("rst_flags", {addr_err[0], seq_err[0], ovf_err[0]}, 0);
      chk("rst_state", dbg_state[0], IDLE);

      // Basic write / read with held handshake
      cmd(0, OP_SET_WADDR, 8'h10, 1'b0);
      cmd(0, OP_WRITE,     8'hA5, 1'b0);
      cmd(0, OP_SET_RADDR, 8'h10, 1'b0);
      cmd(0, OP_READ,      8'h00, 1'b0);
      chk("basic_tx_valid", tx_valid[0], 1);
      chk("basic_dout", dout[0], 8'hA5);
      repeat (3) @(negedge clk);
      chk("basic_held_valid", tx_valid[0], 1);
      chk("basic_held_dout", dout[0], 8'hA5);
      ack_only(0);
      chk("basic_ack_clears", tx_valid[0], 0);

      // Burst with wrap at the top of memory
      cmd(0, OP_SET_WADDR, 8'hFE, 1'b0);
      cmd(0, OP_WRITE,     8'h11, 1'b0);
      cmd(0, OP_WRITE,     8'h22, 1'b0);
      cmd(0, OP_WRITE,     8'h33, 1'b0);
      cmd(0, OP_SET_RADDR, 8'hFE, 1'b0);
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("burst_rd0", dout[0], 8'h11);
      ack_only(0);
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("burst_rd1", dout[0], 8'h22);
      ack_only(0);
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("burst_rd2_wrap", dout[0], 8'h33);
      ack_only(0);
      chk("burst_done_valid", tx_valid[0], 0);
      chk("burst_no_flags", {addr_err[0], seq_err[0], ovf_err[0]}, 0);

      // Overflow drop, then read overlapped with ack
      cmd(0, OP_SET_RADDR, 8'hFE, 1'b0);
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("ovf_first", dout[0], 8'h11);
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("ovf_flag", ovf_err[0], 1);
      chk("ovf_dout_kept", dout[0], 8'h11);
      chk("ovf_valid_kept", tx_valid[0], 1);
      cmd(0, OP_READ, 8'h00, 1'b1);
      chk("overlap_valid", tx_valid[0], 1);
      chk("overlap_dout_next", dout[0], 8'h22);
      cmd(0, OP_READ, 8'h00, 1'b1);
      chk("overlap_dout_wrap", dout[0], 8'h33);

      // Asynchronous reset while a word is pending
      #2 rst[0] = 1'b1;
      #1;
      chk("areset_tx_valid", tx_valid[0], 0);
      chk("areset_dout", dout[0], 0);
      chk("areset_flags", {addr_err[0], seq_err[0], ovf_err[0]}, 0);
      @(negedge clk);
      rst[0] = 1'b0;
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("post_rst_read_seq", seq_err[0], 1);
      chk("post_rst_read_noval", tx_valid[0], 0);

      // Write before address: flagged and not written (memory keeps 0x33 at 0)
      do_reset(0);
      cmd(0, OP_WRITE, 8'h55, 1'b0);
      chk("early_write_seq", seq_err[0], 1);
      cmd(0, OP_SET_RADDR, 8'h00, 1'b0);
      cmd(0, OP_READ, 8'h00, 1'b0);
      chk("early_write_nowrite", dout[0], 8'h33);
      ack_only(0);

      // Depth 200, fixed pointers
      ack_only(1);
      chk("idle_ack_ignored", tx_valid[1], 0);
      cmd(1, OP_SET_WADDR, 8'h05, 1'b0);
      chk("d200_no_addr_err", addr_err[1], 0);
      cmd(1, OP_SET_WADDR, 8'hC8, 1'b0);
      chk("d200_addr_err", addr_err[1], 1);
      cmd(1, OP_WRITE, 8'h77, 1'b0);
      cmd(1, OP_WRITE, 8'h88, 1'b0);
      chk("d200_no_seq_err", seq_err[1], 0);
      cmd(1, OP_SET_RADDR, 8'h05, 1'b0);
      cmd(1, OP_READ, 8'h00, 1'b0);
      chk("noinc_last_wins", dout[1], 8'h88);
      ack_only(1);
      cmd(1, OP_READ, 8'h00, 1'b0);
      chk("noinc_same_word", dout[1], 8'h88);
      ack_only(1);
      cmd(1, OP_SET_WADDR, 8'hC7, 1'b0);
      cmd(1, OP_WRITE, 8'h99, 1'b0);
      cmd(1, OP_SET_RADDR, 8'hC7, 1'b0);
      cmd(1, OP_SET_RADDR, 8'hC8, 1'b0);
      cmd(1, OP_READ, 8'h00, 1'b0);
      chk("d200_last_addr", dout[1], 8'h99);
      ack_only(1);
      chk("d200_final_valid", tx_valid[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
